program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Instruction-address register stage of the RISC datapath, built on the falling-edge, synchronously reset flip-flop style.
- Holds the current PC and feeds the instruction-fetch stage.
- Supports sequential increment, branch/jump load, pipeline stall, and a halt/resume run-control FSM.
- Produces a one-cycle flush pulse to the downstream fetch/decode register after every taken load.

Parameters:
- WIDTH, 8, PC width in bits; all address arithmetic is modulo 2^WIDTH.
- RESET_VEC, 0, PC value loaded by reset; must fit in WIDTH bits.
- STEP, 1, increment added per sequential advance; 1 <= STEP < 2^WIDTH.

Ports:
- CLK  input  1  clock; all state updates on the FALLING edge.
- R  input  1  reset, synchronous, active-low; sampled on the falling edge of CLK.
- LOAD  input  1  branch/jump taken; load LOAD_ADDR.
- LOAD_ADDR  input  WIDTH  branch/jump target.
- STALL  input  1  hold PC for this cycle.
- HALT  input  1  request entry to the HALTED state.
- RESUME  input  1  request return from HALTED to RUN.
- PC  output  WIDTH  current instruction address (registered).
- PC_PLUS1  output  WIDTH  combinational (PC + STEP) mod 2^WIDTH, used as the link value.
- FLUSH  output  1  registered; high for the cycle after an accepted load.
- WRAP  output  1  registered; high for the cycle after an increment that overflowed.
- HALTED  output  1  registered; high while the FSM is in HALTED.

Behaviour:
- All registers update only on the falling edge of CLK. No rising-edge or asynchronous paths.
- Reset: R=0 at a falling edge forces the following values, regardless of any other input or state:
  - PC=RESET_VEC
  - FSM=RUN
  - FLUSH=0, WRAP=0, HALTED=0
- Reset mid-halt exits halt. Reset while LOAD=1 discards the load.
- FSM states: RUN and HALTED. HALTED output equals (state==HALTED).
- RUN, priority per falling edge with R=1:
  1. HALT=1: go to HALTED. PC holds. LOAD and STALL in the same cycle are dropped. FLUSH=0, WRAP=0.
  2. Else LOAD=1: PC<=LOAD_ADDR, FLUSH<=1, WRAP<=0. LOAD wins over STALL.
  3. Else STALL=1: PC holds, FLUSH<=0, WRAP<=0.
  4. Else: PC<=(PC+STEP) mod 2^WIDTH, FLUSH<=0. WRAP<=1 iff PC+STEP >= 2^WIDTH (carry out), else 0.
- HALTED:
  - PC, FLUSH=0, WRAP=0 hold. LOAD and STALL are ignored.
  - RESUME=1 and HALT=0: go to RUN. PC still holds on that edge; the first advance happens on the next edge.
  - RESUME=1 and HALT=1 together: stay in HALTED.
- Latency:
  - PC changes one falling edge after the controlling input is sampled.
  - FLUSH and WRAP are valid in the same cycle as the new PC.
  - PC_PLUS1 tracks PC with zero latency.
- Back-to-back LOADs: PC follows each target, and FLUSH stays high continuously.
- LOAD_ADDR equal to the current PC is still a taken load: FLUSH=1.
- Width rule: the carry out of the adder is used only for WRAP. PC never exceeds 2^WIDTH-1.

Test Plan:
- Reset and run: hold R=0 for 2 falling edges, then R=1 with no controls (WIDTH=8, STEP=1) -> PC=0x00, then 0x01, 0x02, 0x03 on successive edges. HALTED=FLUSH=WRAP=0 throughout.
- Wrap-around: LOAD=1, LOAD_ADDR=0xFE for one edge, then idle -> PC=0xFE with FLUSH=1; PC=0xFF with FLUSH=0, WRAP=0; PC=0x00 with WRAP=1; PC=0x01 with WRAP=0.
- Stall vs load priority: at PC=0x10, set STALL=1 for 2 edges -> PC stays 0x10. Then STALL=1 and LOAD=1 with LOAD_ADDR=0x40 -> PC=0x40, FLUSH=1. PC_PLUS1=0x41 in the same cycle.
- Halt/resume:
  - At PC=0x20, assert HALT together with LOAD=1, LOAD_ADDR=0x80 -> HALTED=1, PC=0x20, FLUSH=0.
  - LOAD pulses while halted -> PC stays 0x20.
  - HALT=1 and RESUME=1 together -> remains HALTED.
  - RESUME=1 alone -> HALTED=0 with PC=0x20, then 0x21 on the next edge.
- Reset mid-operation: while HALTED with PC=0x33, drive R=0 for one edge -> PC=RESET_VEC (0x00), HALTED=0, FLUSH=0. Repeat with LOAD=1 during reset -> load ignored.
- Edge sensitivity: toggle LOAD/LOAD_ADDR only between a rising edge and the following falling edge, then check that PC is unchanged at the rising edge and updates only at the falling edge.

Source files
------------

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// program_counter : falling-edge instruction-address register with run/halt
// Revision 1.0 - initial release
// ============================================================================
module program_counter #(
    parameter int WIDTH     = 8,
    parameter int RESET_VEC = 0,
    parameter int STEP      = 1
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_ADDR,
    input  logic             STALL,
    input  logic             HALT,
    input  logic             RESUME,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PC_PLUS1,
    output logic             FLUSH,
    output logic             WRAP,
    output logic             HALTED
);

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc_next;
    logic             flush_next;
    logic             wrap_next;
    logic [WIDTH:0]   sum;

    // Extra MSB of the adder is the carry; it only feeds WRAP.
    assign sum      = {1'b0, PC} + STEP_EXT;
    assign PC_PLUS1 = sum[WIDTH-1:0];
    assign HALTED   = (state == ST_HALTED);

    always_comb begin
        state_next = state;
        pc_next    = PC;
        flush_next = 1'b0;
        wrap_next  = 1'b0;
        case (state)
            ST_RUN: begin
                if (HALT) begin
                    state_next = ST_HALTED;
                end else if (LOAD) begin
                    pc_next    = LOAD_ADDR;
                    flush_next = 1'b1;
                end else if (!STALL) begin
                    pc_next   = sum[WIDTH-1:0];
                    wrap_next = sum[WIDTH];
                end
            end
            ST_HALTED: begin
                // Resume only releases the FSM; PC advances on the following edge.
                if (RESUME && !HALT) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(negedge CLK) begin
        if (!R) begin
            state <= ST_RUN;
            PC    <= RESET_PC;
            FLUSH <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            state <= state_next;
            PC    <= pc_next;
            FLUSH <= flush_next;
            WRAP  <= wrap_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// tb_program_counter : directed self-checking bench for program_counter
// Revision 1.0 - initial release
// ============================================================================
module tb_program_counter;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             R;
    logic             LOAD;
    logic [WIDTH-1:0] LOAD_ADDR;
    logic             STALL;
    logic             HALT;
    logic             RESUME;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] PC_PLUS1;
    logic             FLUSH;
    logic             WRAP;
    logic             HALTED;

    int checks   = 0;
    int failures = 0;

    program_counter #(
        .WIDTH    (WIDTH),
        .RESET_VEC(0),
        .STEP     (1)
    ) dut (
        .CLK      (CLK),
        .R        (R),
        .LOAD     (LOAD),
        .LOAD_ADDR(LOAD_ADDR),
        .STALL    (STALL),
        .HALT     (HALT),
        .RESUME   (RESUME),
        .PC       (PC),
        .PC_PLUS1 (PC_PLUS1),
        .FLUSH    (FLUSH),
        .WRAP     (WRAP),
        .HALTED   (HALTED)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one falling edge and settle just after it.
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [7:0] pc, input logic fl,
                                input logic wr, input logic ht);
        check({tag, ".pc"}, 32'(PC), 32'(pc));
        check({tag, ".flush"}, 32'(FLUSH), 32'(fl));
        check({tag, ".wrap"}, 32'(WRAP), 32'(wr));
        check({tag, ".halted"}, 32'(HALTED), 32'(ht));
    endtask

    initial begin
        R = 1'b0; LOAD = 1'b0; LOAD_ADDR = '0; STALL = 1'b0; HALT = 1'b0; RESUME = 1'b0;

        // Reset and run
        tick(); tick();
        expect_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.plus1", 32'(PC_PLUS1), 32'h01);
        R = 1'b1;
        tick(); expect_state("run1", 8'h01, 1'b0, 1'b0, 1'b0);
        tick(); expect_state("run2", 8'h02, 1'b0, 1'b0, 1'b0);
        tick(); expect_state("run3", 8'h03, 1'b0, 1'b0, 1'b0);

        // Wrap-around
        LOAD = 1'b1; LOAD_ADDR = 8'hFE;
        tick(); expect_state("wrap.load", 8'hFE, 1'b1, 1'b0, 1'b0);
        LOAD = 1'b0;
        tick(); expect_state("wrap.ff", 8'hFF, 1'b0, 1'b0, 1'b0);
        check("wrap.plus1", 32'(PC_PLUS1), 32'h00);
        tick(); expect_state("wrap.00", 8'h00, 1'b0, 1'b1, 1'b0);
        tick(); expect_state("wrap.01", 8'h01, 1'b0, 1'b0, 1'b0);

        // Stall vs load priority
        LOAD = 1'b1; LOAD_ADDR = 8'h10;
        tick(); expect_state("stall.setup", 8'h10, 1'b1, 1'b0, 1'b0);
        LOAD = 1'b0; STALL = 1'b1;
        tick(); expect_state("stall1", 8'h10, 1'b0, 1'b0, 1'b0);
        tick(); expect_state("stall2", 8'h10, 1'b0, 1'b0, 1'b0);
        LOAD = 1'b1; LOAD_ADDR = 8'h40;
        tick(); expect_state("stall.load", 8'h40, 1'b1, 1'b0, 1'b0);
        check("stall.plus1", 32'(PC_PLUS1), 32'h41);
        STALL = 1'b0;

        // Back-to-back loads, including a target equal to the current PC
        LOAD_ADDR = 8'h40;
        tick(); expect_state("b2b.same", 8'h40, 1'b1, 1'b0, 1'b0);
        LOAD_ADDR = 8'h55;
        tick(); expect_state("b2b.next", 8'h55, 1'b1, 1'b0, 1'b0);

        // Halt / resume
        LOAD_ADDR = 8'h20;
        tick(); expect_state("halt.setup", 8'h20, 1'b1, 1'b0, 1'b0);
        HALT = 1'b1; LOAD_ADDR = 8'h80;
        tick(); expect_state("halt.enter", 8'h20, 1'b0, 1'b0, 1'b1);
        HALT = 1'b0; LOAD_ADDR = 8'h99;
        tick(); expect_state("halt.load", 8'h20, 1'b0, 1'b0, 1'b1);
        LOAD = 1'b0; STALL = 1'b1;
        tick(); expect_state("halt.idle", 8'h20, 1'b0, 1'b0, 1'b1);
        STALL = 1'b0; HALT = 1'b1; RESUME = 1'b1;
        tick(); expect_state("halt.both", 8'h20, 1'b0, 1'b0, 1'b1);
        HALT = 1'b0;
        tick(); expect_state("resume", 8'h20, 1'b0, 1'b0, 1'b0);
        RESUME = 1'b0;
        tick(); expect_state("resume.adv", 8'h21, 1'b0, 1'b0, 1'b0);

        // Reset mid-halt
        LOAD = 1'b1; LOAD_ADDR = 8'h33;
        tick();
        LOAD = 1'b0; HALT = 1'b1;
        tick(); expect_state("rst.halted", 8'h33, 1'b0, 1'b0, 1'b1);
        HALT = 1'b0; R = 1'b0;
        tick(); expect_state("rst.mid", 8'h00, 1'b0, 1'b0, 1'b0);
        R = 1'b1;
        tick(); expect_state("rst.after", 8'h01, 1'b0, 1'b0, 1'b0);

        // Reset with a concurrent load
        LOAD = 1'b1; LOAD_ADDR = 8'h33;
        tick();
        LOAD = 1'b0; HALT = 1'b1;
        tick();
        HALT = 1'b0; R = 1'b0; LOAD = 1'b1; LOAD_ADDR = 8'h77;
        tick(); expect_state("rst.load", 8'h00, 1'b0, 1'b0, 1'b0);
        R = 1'b1; LOAD = 1'b0;
        tick(); expect_state("rst.load.after", 8'h01, 1'b0, 1'b0, 1'b0);

        // Edge sensitivity: inputs change after a rising edge, PC moves only on the falling edge
        @(posedge CLK);
        #1;
        LOAD = 1'b1; LOAD_ADDR = 8'hC3;
        #1;
        check("edge.hold.pc", 32'(PC), 32'h01);
        check("edge.hold.flush", 32'(FLUSH), 32'h0);
        @(negedge CLK);
        #1;
        check("edge.fall.pc", 32'(PC), 32'hC3);
        check("edge.fall.flush", 32'(FLUSH), 32'h1);
        LOAD = 1'b0;
        @(posedge CLK);
        #1;
        check("edge.rise.pc", 32'(PC), 32'hC3);
        @(negedge CLK);
        #1;
        check("edge.adv.pc", 32'(PC), 32'hC4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
